amba3_axi_sram_slave: RTL and testbench

//  Synthesizable AXI3 responder (slave end of amba3_axi_if) backed by an internal

---
 rtl/amba3_axi_sram_slave.sv | 232 +++++++++++++++++++++++
 tb/tb_amba3_axi_sram_slave.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/amba3_axi_sram_slave.sv
// AXI3 responder backed by a register-array memory; independent write and read burst FSMs.
// Latency: first R beat one cycle after AR, B one cycle after the final W beat; R/B held while rready/bready low.
module amba3_axi_sram_slave #(
  parameter int AXID_SIZE = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 128,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                   aclk,
  input  logic                   areset_n,
  input  logic [AXID_SIZE-1:0]   awid,
  input  logic [ADDR_SIZE-1:0]   awaddr,
  input  logic [3:0]             awlen,
  input  logic [2:0]             awsize,
  input  logic [1:0]             awburst,
  input  logic [1:0]             awlock,
  input  logic [3:0]             awcache,
  input  logic [2:0]             awprot,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [AXID_SIZE-1:0]   wid,
  input  logic [DATA_SIZE-1:0]   wdata,
  input  logic [DATA_SIZE/8-1:0] wstrb,
  input  logic                   wlast,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [AXID_SIZE-1:0]   bid,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  input  logic [AXID_SIZE-1:0]   arid,
  input  logic [ADDR_SIZE-1:0]   araddr,
  input  logic [3:0]             arlen,
  input  logic [2:0]             arsize,
  input  logic [1:0]             arburst,
  input  logic [1:0]             arlock,
  input  logic [3:0]             arcache,
  input  logic [2:0]             arprot,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [AXID_SIZE-1:0]   rid,
  output logic [DATA_SIZE-1:0]   rdata,
  output logic [1:0]             rresp,
  output logic                   rlast,
  output logic                   rvalid,
  input  logic                   rready
);
  localparam int STRB_SIZE = DATA_SIZE / 8;
  localparam int BSH       = $clog2(STRB_SIZE);
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [2:0]           MAX_SIZE = 3'(BSH);
  localparam logic [ADDR_SIZE-1:0] DEPTH_A  = ADDR_SIZE'(MEM_DEPTH);
  localparam logic [1:0] B_FIXED = 2'b00, B_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

  logic unused_sigs;
  assign unused_sigs = ^{awlock, awcache, awprot, arlock, arcache, arprot};

  function automatic logic wrap_len_ok(input logic [3:0] len);
    return len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15;
  endfunction

  // Per-burst error independent of address: oversize beats, or WRAP with an illegal length.
  function automatic logic burst_err(input logic [2:0] size, input logic [3:0] len,
                                     input logic [1:0] burst);
    return (size > MAX_SIZE) || (burst == B_WRAP && !wrap_len_ok(len));
  endfunction

  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] addr,
      input logic [2:0] size, input logic [3:0] len, input logic [1:0] burst);
    logic [ADDR_SIZE-1:0] sz, span, inc;
    sz   = ADDR_SIZE'(1) << size;
    span = (ADDR_SIZE'(len) + ADDR_SIZE'(1)) * sz;
    inc  = (addr & ~(sz - ADDR_SIZE'(1))) + sz;
    if (burst == B_FIXED) return addr;
    if (burst == B_WRAP && wrap_len_ok(len))
      return (addr & ~(span - ADDR_SIZE'(1))) | (inc & (span - ADDR_SIZE'(1)));
    return inc;
  endfunction

  // ---------------- write channel ----------------
  w_state_t             w_state, w_next;
  logic [AXID_SIZE-1:0] w_id;
  logic [ADDR_SIZE-1:0] w_addr, w_word;
  logic [3:0]           w_len, w_beat;
  logic [2:0]           w_size;
  logic [1:0]           w_burst, w_err, w_beat_resp;
  logic                 w_oob, w_last, w_fire, w_we;

  assign awready = (w_state == W_IDLE);
  assign wready  = (w_state == W_DATA);
  assign bvalid  = (w_state == W_RESP);
  assign bid     = w_id;
  assign bresp   = w_err;

  assign w_word = w_addr >> BSH;
  assign w_oob  = (w_word >= DEPTH_A);
  assign w_last = (w_beat == w_len);
  assign w_fire = wvalid && wready;
  assign w_we   = w_fire && !w_oob && (w_size <= MAX_SIZE);
  assign w_beat_resp = w_oob ? RESP_DECERR :
                       ((wid != w_id) || (wlast != w_last)) ? RESP_SLVERR : RESP_OKAY;

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (awvalid)           w_next = W_DATA;
      W_DATA:  if (wvalid && w_last)  w_next = W_RESP;
      W_RESP:  if (bready)            w_next = W_IDLE;
      default:                        w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_beat  <= '0;
      w_err   <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      if (awvalid && awready) begin
        w_id    <= awid;
        w_addr  <= awaddr;
        w_len   <= awlen;
        w_size  <= awsize;
        w_burst <= awburst;
        w_beat  <= '0;
        w_err   <= burst_err(awsize, awlen, awburst) ? RESP_SLVERR : RESP_OKAY;
      end
      if (w_fire) begin
        w_beat <= w_beat + 4'd1;
        w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
        if (w_beat_resp > w_err) w_err <= w_beat_resp;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_we)
      for (int i = 0; i < STRB_SIZE; i++)
        if (wstrb[i]) mem[w_word[IDX_W-1:0]][8*i +: 8] <= wdata[8*i +: 8];
  end

  // ---------------- read channel ----------------
  r_state_t             r_state, r_next;
  logic [ADDR_SIZE-1:0] r_addr, f_addr, f_word;
  logic [3:0]           r_len, r_beat, f_len;
  logic [2:0]           r_size, f_size;
  logic [1:0]           r_burst, f_burst, f_resp;
  logic [DATA_SIZE-1:0] f_data;
  logic                 f_oob;

  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_DATA);

  // Fetch path: the AR address when idle, otherwise the following beat of the active burst.
  always_comb begin
    f_addr  = araddr;
    f_size  = arsize;
    f_len   = arlen;
    f_burst = arburst;
    if (r_state == R_DATA) begin
      f_addr  = next_addr(r_addr, r_size, r_len, r_burst);
      f_size  = r_size;
      f_len   = r_len;
      f_burst = r_burst;
    end
  end

  assign f_word = f_addr >> BSH;
  assign f_oob  = (f_word >= DEPTH_A);
  assign f_resp = f_oob ? RESP_DECERR :
                  burst_err(f_size, f_len, f_burst) ? RESP_SLVERR : RESP_OKAY;
  assign f_data = (f_oob || f_size > MAX_SIZE) ? '0 : mem[f_word[IDX_W-1:0]];

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (arvalid)          r_next = R_DATA;
      R_DATA:  if (rready && rlast)  r_next = R_IDLE;
      default:                       r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_beat  <= '0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      rlast   <= 1'b0;
    end else begin
      r_state <= r_next;
      if (arvalid && arready) begin
        r_addr  <= araddr;
        r_len   <= arlen;
        r_size  <= arsize;
        r_burst <= arburst;
        r_beat  <= '0;
        rid     <= arid;
        rdata   <= f_data;
        rresp   <= f_resp;
        rlast   <= (arlen == 4'd0);
      end else if (rvalid && rready) begin
        if (rlast) begin
          rlast <= 1'b0;
        end else begin
          r_addr <= f_addr;
          r_beat <= r_beat + 4'd1;
          rdata  <= f_data;
          rresp  <= f_resp;
          rlast  <= ((r_beat + 4'd1) == r_len);
        end
      end
    end
  end
endmodule

// File: tb/tb_amba3_axi_sram_slave.sv
// Randomized bench for amba3_axi_sram_slave against an array-based memory and AXI address model.
// Directed bursts cover INCR/WRAP/partial strobes/decode and slave errors/reset; random bursts follow.
module tb_amba3_axi_sram_slave;
  logic         aclk = 1'b0;
  logic         areset_n = 1'b0;
  logic [3:0]   awid, wid, bid, arid, rid;
  logic [31:0]  awaddr, araddr;
  logic [3:0]   awlen, arlen, awcache, arcache;
  logic [2:0]   awsize, arsize, awprot, arprot;
  logic [1:0]   awburst, arburst, awlock, arlock, bresp, rresp;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic [127:0] wdata, rdata;
  logic [15:0]  wstrb;

  int vectors = 0;
  int miscompares = 0;
  logic [127:0] ref_mem [1024];
  logic [127:0] wd [16];
  logic [15:0]  ws [16];

  always #5 aclk = ~aclk;

  amba3_axi_sram_slave dut (
    .aclk(aclk), .areset_n(areset_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Address of beat i from the AXI burst rules, computed directly rather than iteratively.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                            input int burst, input int i);
    longint aa, sb, al, span, lo;
    aa = longint'(a);
    sb = longint'(1) << size;
    al = (aa / sb) * sb;
    if (burst == 0 || i == 0) return a;
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      span = (len + 1) * sb;
      lo   = (aa / span) * span;
      return 32'(lo + ((al - lo) + i * sb) % span);
    end
    return 32'(al + i * sb);
  endfunction

  function automatic logic [1:0] beat_resp(input logic [31:0] a, input int len, input int size,
                                           input int burst);
    if ((a >> 4) >= 1024) return 2'b11;
    if (size > 4 || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15))) return 2'b10;
    return 2'b00;
  endfunction

  task automatic axi_write(input logic [3:0] id, input logic [31:0] a, input int len,
                           input int size, input int burst, input int wlast_at, input int badid_at);
    int n;
    int d;
    logic [1:0]  exp_resp;
    logic [1:0]  r;
    logic [31:0] ba;
    exp_resp = 2'b00;
    @(negedge aclk);
    awid = id; awaddr = a; awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst); awvalid = 1'b1;
    n = 0;
    while (!awready && n < 200) begin @(negedge aclk); n++; end
    check_val("aw_timeout", n >= 200, 0);
    @(negedge aclk);
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if ($urandom_range(3) == 0) begin wvalid = 1'b0; @(negedge aclk); end
      ba = beat_addr(a, len, size, burst, i);
      r  = beat_resp(ba, len, size, burst);
      wid   = (i == badid_at) ? ~id : id;
      wlast = (wlast_at < 0) ? (i == len) : (i == wlast_at);
      if ((wid != id || wlast != (i == len)) && r < 2'b10) r = 2'b10;
      if (r > exp_resp) exp_resp = r;
      if ((ba >> 4) < 1024 && size <= 4)
        for (int b = 0; b < 16; b++)
          if (ws[i][b]) ref_mem[ba[13:4]][8*b +: 8] = wd[i][8*b +: 8];
      wdata = wd[i]; wstrb = ws[i]; wvalid = 1'b1;
      n = 0;
      while (!wready && n < 200) begin @(negedge aclk); n++; end
      check_val("w_timeout", n >= 200, 0);
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check_val("w_done_wready", wready, 0);
    d = $urandom_range(2);
    for (int j = 0; j <= d; j++) begin
      check_val("bvalid", bvalid, 1);
      check_val("bid", bid, id);
      check_val("bresp", bresp, exp_resp);
      if (j == d) bready = 1'b1;
      @(negedge aclk);
    end
    bready = 1'b0;
    check_val("b_done_bvalid", bvalid, 0);
    check_val("b_done_awready", awready, 1);
  endtask

  // stall: 0 = rready always high, 1 = random, 2 = toggling
  task automatic axi_read(input logic [3:0] id, input logic [31:0] a, input int len,
                          input int size, input int burst, input int stall);
    logic [127:0] ed [16];
    logic [1:0]   er [16];
    logic [31:0]  ba;
    int n, k, cyc;
    for (int i = 0; i <= len; i++) begin
      ba    = beat_addr(a, len, size, burst, i);
      er[i] = beat_resp(ba, len, size, burst);
      ed[i] = (er[i] == 2'b11 || size > 4) ? 128'h0 : ref_mem[ba[13:4]];
    end
    @(negedge aclk);
    arid = id; araddr = a; arlen = 4'(len); arsize = 3'(size); arburst = 2'(burst); arvalid = 1'b1;
    n = 0;
    while (!arready && n < 200) begin @(negedge aclk); n++; end
    check_val("ar_timeout", n >= 200, 0);
    @(negedge aclk);
    arvalid = 1'b0;
    k = 0; cyc = 0;
    while (k <= len && cyc < 200) begin
      rready = (stall == 0) ? 1'b1 : (stall == 2) ? (cyc % 2 == 0) : 1'($urandom_range(1));
      check_val("rvalid", rvalid, 1);
      check_val("rid", rid, id);
      check_val("rdata", rdata, ed[k]);
      check_val("rresp", rresp, er[k]);
      check_val("rlast", rlast, k == len);
      if (rvalid && rready) k++;
      @(negedge aclk);
      cyc++;
    end
    rready = 1'b0;
    check_val("r_timeout", cyc >= 200, 0);
    if (stall == 0) check_val("r_cycles", cyc, len + 1);
    check_val("r_done_rvalid", rvalid, 0);
    check_val("r_done_rlast", rlast, 0);
    check_val("r_done_arready", arready, 1);
  endtask

  initial begin
    int n, sz, ln, bu;
    logic [31:0] a;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awlock = 0; awcache = 0; awprot = 0;
    awvalid = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arlock = 0; arcache = 0; arprot = 0;
    arvalid = 0; rready = 0;

    repeat (3) @(negedge aclk);
    check_val("rst_awready", awready, 1);
    check_val("rst_arready", arready, 1);
    check_val("rst_wready", wready, 0);
    check_val("rst_bvalid", bvalid, 0);
    check_val("rst_rvalid", rvalid, 0);
    check_val("rst_rlast", rlast, 0);
    check_val("rst_ids", {bid, rid}, 0);
    check_val("rst_rdata", rdata, 0);
    check_val("rst_resps", {bresp, rresp}, 0);
    areset_n = 1'b1;

    // Fill the whole memory so every later read has a known expected value.
    for (int b = 0; b < 64; b++) begin
      for (int i = 0; i < 16; i++) begin
        wd[i] = {$urandom, $urandom, $urandom, $urandom};
        ws[i] = 16'hFFFF;
      end
      axi_write(4'(b), 32'(b * 256), 15, 4, 1, -1, -1);
    end

    for (int i = 0; i < 4; i++) begin
      wd[i] = {16{8'(8'hAA + 17 * i)}};
      ws[i] = 16'hFFFF;
    end
    axi_write(4'h3, 32'h100, 3, 4, 1, -1, -1);
    axi_read(4'h3, 32'h100, 3, 4, 1, 0);
    axi_read(4'h9, 32'h130, 3, 4, 2, 1);

    wd[0] = '1; ws[0] = 16'hFFFF;
    axi_write(4'h1, 32'h180, 0, 4, 1, -1, -1);
    wd[0] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; ws[0] = 16'h00FF;
    axi_write(4'h1, 32'h180, 0, 4, 1, -1, -1);
    axi_read(4'h1, 32'h180, 0, 4, 1, 2);
    axi_read(4'h1, 32'h170, 3, 4, 1, 2);

    for (int i = 0; i < 2; i++) begin wd[i] = {4{$urandom}}; ws[i] = 16'hFFFF; end
    axi_write(4'h4, 32'h4000, 1, 4, 1, -1, -1);
    axi_read(4'h4, 32'h4000, 0, 4, 1, 0);
    axi_read(4'h4, 32'h0, 0, 4, 1, 0);
    axi_read(4'h4, 32'h3FF0, 0, 4, 1, 0);

    for (int i = 0; i < 4; i++) begin wd[i] = {4{$urandom}}; ws[i] = 16'hFFFF; end
    axi_write(4'h5, 32'h200, 3, 4, 1, 1, -1);
    axi_write(4'h6, 32'h300, 0, 5, 1, -1, -1);
    axi_read(4'h6, 32'h300, 0, 5, 1, 0);
    axi_read(4'h6, 32'h300, 0, 4, 1, 0);
    axi_write(4'h7, 32'h310, 1, 4, 1, -1, 0);
    axi_write(4'h8, 32'h340, 2, 4, 2, -1, -1);
    axi_read(4'h8, 32'h340, 2, 4, 2, 1);

    for (int i = 0; i < 4; i++) begin wd[i] = {4{$urandom}}; ws[i] = 16'($urandom); end
    fork
      axi_write(4'hA, 32'h800, 3, 4, 1, -1, -1);
      axi_read(4'hB, 32'hA00, 3, 4, 1, 1);
    join
    axi_read(4'hA, 32'h800, 3, 4, 1, 0);

    // Reset while beat 2 of an 8-beat read is on the bus.
    @(negedge aclk);
    arid = 4'hC; araddr = 32'h200; arlen = 4'd7; arsize = 3'd4; arburst = 2'd1; arvalid = 1'b1;
    rready = 1'b1;
    n = 0;
    while (!arready && n < 200) begin @(negedge aclk); n++; end
    check_val("rst6_ar_timeout", n >= 200, 0);
    @(negedge aclk);
    arvalid = 1'b0;
    repeat (2) @(negedge aclk);
    check_val("rst6_beat2", rdata, ref_mem[(32'h200 >> 4) + 2]);
    areset_n = 1'b0;
    #1;
    check_val("rst6_rvalid", rvalid, 0);
    check_val("rst6_arready", arready, 1);
    check_val("rst6_rlast", rlast, 0);
    @(negedge aclk);
    areset_n = 1'b1; rready = 1'b0;
    axi_read(4'hC, 32'h200, 7, 4, 1, 1);

    repeat (40) begin
      sz = ($urandom_range(3) == 0) ? $urandom_range(0, 3) : 4;
      ln = $urandom_range(0, 15);
      bu = $urandom_range(0, 2);
      a  = 32'($urandom_range(0, 1000) * 16 + ($urandom_range(0, 15) & ~((1 << sz) - 1)));
      if ($urandom_range(1) == 1) begin
        for (int i = 0; i < 16; i++) begin
          wd[i] = {$urandom, $urandom, $urandom, $urandom};
          ws[i] = 16'($urandom);
        end
        axi_write(4'($urandom), a, ln, sz, bu, -1, -1);
      end else begin
        axi_read(4'($urandom), a, ln, sz, bu, $urandom_range(0, 2));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
